execute_stage: RTL and testbench

- E stage of the five-stage MIPS pipeline, directly upstream of the memory stage.
- Takes decoded operands and control from the D/E side and applies the forwarding selects supplied by the hazard unit.
- Computes the ALU result and runs an iterative multiply/divide unit with HI/LO registers.
- Registers ALU result, store data and control into the E/M boundary consumed by the memory stage.

---
 rtl/execute_stage_pkg.sv | 49 ++++
 rtl/execute_stage_md_unit.sv | 141 ++++++++++++++
 rtl/execute_stage.sv | 151 +++++++++++++++
 tb/tb_execute_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_pkg
//  Description : Shared encodings for the execute stage. Holds the ALU
//                operation codes, the multiply/divide operation codes, the
//                forwarding-select codes and the MD state machine encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package execute_stage_pkg;

    // ALU operation codes (ALUCtrlD)
    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_NOR  = 4'd5;
    localparam logic [3:0] c_ALU_SLT  = 4'd6;
    localparam logic [3:0] c_ALU_SLTU = 4'd7;
    localparam logic [3:0] c_ALU_SLL  = 4'd8;
    localparam logic [3:0] c_ALU_SRL  = 4'd9;
    localparam logic [3:0] c_ALU_SRA  = 4'd10;
    localparam logic [3:0] c_ALU_LUI  = 4'd11;

    // Multiply/divide operation codes (MDOpD)
    localparam logic [3:0] c_MD_NONE  = 4'd0;
    localparam logic [3:0] c_MD_MULT  = 4'd1;
    localparam logic [3:0] c_MD_MULTU = 4'd2;
    localparam logic [3:0] c_MD_DIV   = 4'd3;
    localparam logic [3:0] c_MD_DIVU  = 4'd4;
    localparam logic [3:0] c_MD_MFHI  = 4'd5;
    localparam logic [3:0] c_MD_MFLO  = 4'd6;
    localparam logic [3:0] c_MD_MTHI  = 4'd7;
    localparam logic [3:0] c_MD_MTLO  = 4'd8;

    // Forwarding selects (FwdAE / FwdBE); code 3 behaves like c_FWD_REG
    localparam logic [1:0] c_FWD_REG  = 2'd0;
    localparam logic [1:0] c_FWD_M    = 2'd1;
    localparam logic [1:0] c_FWD_W    = 2'd2;

    // Multiply/divide unit state
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/execute_stage_md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_md_unit
//  Description : Iterative multiply/divide unit with HI/LO registers. The
//                result is computed at issue and held until the cycle count
//                expires, then committed to HI/LO.
//  Ports       : clk, i_rst_n (async active-low), i_md_op (MD op code),
//                i_a / i_b (forwarded rs / rt), o_hi / o_lo (HI/LO),
//                o_busy (unit occupied), o_stall (stall request)
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_md_unit
    import execute_stage_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_stall
);

    localparam logic [3:0] c_MULT_LAST = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] c_DIV_LAST  = 4'(DIV_CYCLES - 1);

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_we;
    logic        r_start_pending;

    logic        w_busy;
    logic        w_stall;
    logic        w_start_mult;
    logic        w_start_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_divisor;
    logic        w_div_ovf;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign w_busy  = (r_state != MD_IDLE);
    // r_start_pending covers the cycle right after an issue
    assign w_stall = (i_md_op != c_MD_NONE) && (w_busy || r_start_pending);

    assign w_start_mult = (r_state == MD_IDLE) && !w_stall &&
                          ((i_md_op == c_MD_MULT) || (i_md_op == c_MD_MULTU));
    assign w_start_div  = (r_state == MD_IDLE) && !w_stall &&
                          ((i_md_op == c_MD_DIV) || (i_md_op == c_MD_DIVU));

    // Sign-extending both operands to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // A zero divisor never commits; substitute 1 to keep the divider defined.
    assign w_divisor = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_quot_u  = i_a / w_divisor;
    assign w_rem_u   = i_a % w_divisor;

    always_comb begin
        w_quot_s = 32'sd0;
        w_rem_s  = 32'sd0;
        if (w_div_ovf) begin
            // Most-negative / -1 wraps back to the most-negative value
            w_quot_s = 32'sh8000_0000;
            w_rem_s  = 32'sd0;
        end else begin
            w_quot_s = $signed(i_a) / $signed(w_divisor);
            w_rem_s  = $signed(i_a) % $signed(w_divisor);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= MD_IDLE;
            r_cnt           <= 4'd0;
            r_hi            <= 32'd0;
            r_lo            <= 32'd0;
            r_pend_hi       <= 32'd0;
            r_pend_lo       <= 32'd0;
            r_pend_we       <= 1'b0;
            r_start_pending <= 1'b0;
        end else begin
            r_start_pending <= w_start_mult || w_start_div;
            case (r_state)
                MD_IDLE: begin
                    if (w_start_mult) begin
                        r_state   <= MD_MULT;
                        r_cnt     <= c_MULT_LAST;
                        r_pend_we <= 1'b1;
                        r_pend_hi <= (i_md_op == c_MD_MULT) ? w_prod_s[63:32] : w_prod_u[63:32];
                        r_pend_lo <= (i_md_op == c_MD_MULT) ? w_prod_s[31:0]  : w_prod_u[31:0];
                    end else if (w_start_div) begin
                        r_state   <= MD_DIV;
                        r_cnt     <= c_DIV_LAST;
                        r_pend_we <= (i_b != 32'd0);
                        r_pend_hi <= (i_md_op == c_MD_DIV) ? w_rem_s  : w_rem_u;
                        r_pend_lo <= (i_md_op == c_MD_DIV) ? w_quot_s : w_quot_u;
                    end else if (!w_stall && (i_md_op == c_MD_MTHI)) begin
                        r_hi <= i_a;
                    end else if (!w_stall && (i_md_op == c_MD_MTLO)) begin
                        r_lo <= i_a;
                    end
                end
                MD_MULT, MD_DIV: begin
                    if (r_cnt == 4'd0) begin
                        if (r_pend_we) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_state <= MD_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign o_hi    = r_hi;
    assign o_lo    = r_lo;
    assign o_busy  = w_busy;
    assign o_stall = w_stall;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : E stage of the five-stage MIPS pipeline. Applies operand
//                forwarding, computes the ALU result, drives the multiply/
//                divide unit and registers the E/M boundary.
//  Ports       : clk, reset (async active-low); D-side controls RegWriteD,
//                SDtoRegD, MemWriteD, ALUCtrlD, ALUSrcD, MDOpD; operands
//                RD1D, RD2D, ImmD, ShamtD, WriteRegD, PCD; forwarding FwdAE,
//                FwdBE, FwdM, ResultW; E/M outputs RegWriteE, MemWriteE,
//                SDtoRegE, ALUOutE, WriteDataE, WriteRegE, PCE; status MDBusy,
//                MDStall.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteD,
    input  logic [1:0]  SDtoRegD,
    input  logic        MemWriteD,
    input  logic [3:0]  ALUCtrlD,
    input  logic        ALUSrcD,
    input  logic [3:0]  MDOpD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmD,
    input  logic [4:0]  ShamtD,
    input  logic [4:0]  WriteRegD,
    input  logic [31:0] PCD,
    input  logic [1:0]  FwdAE,
    input  logic [1:0]  FwdBE,
    input  logic [31:0] FwdM,
    input  logic [31:0] ResultW,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic [1:0]  SDtoRegE,
    output logic [31:0] ALUOutE,
    output logic [31:0] WriteDataE,
    output logic [4:0]  WriteRegE,
    output logic [31:0] PCE,
    output logic        MDBusy,
    output logic        MDStall
);

    logic [31:0] w_a;
    logic [31:0] w_bfwd;
    logic [31:0] w_b;
    logic [31:0] w_alu;
    logic [31:0] w_result;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_busy;
    logic        w_stall;

    always_comb begin
        case (FwdAE)
            c_FWD_M: w_a = FwdM;
            c_FWD_W: w_a = ResultW;
            default: w_a = RD1D;
        endcase
        case (FwdBE)
            c_FWD_M: w_bfwd = FwdM;
            c_FWD_W: w_bfwd = ResultW;
            default: w_bfwd = RD2D;
        endcase
    end

    assign w_b = ALUSrcD ? ImmD : w_bfwd;

    always_comb begin
        case (ALUCtrlD)
            c_ALU_ADD:  w_alu = w_a + w_b;
            c_ALU_SUB:  w_alu = w_a - w_b;
            c_ALU_AND:  w_alu = w_a & w_b;
            c_ALU_OR:   w_alu = w_a | w_b;
            c_ALU_XOR:  w_alu = w_a ^ w_b;
            c_ALU_NOR:  w_alu = ~(w_a | w_b);
            c_ALU_SLT:  w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
            c_ALU_SLTU: w_alu = {31'd0, w_a < w_b};
            c_ALU_SLL:  w_alu = w_b << ShamtD;
            c_ALU_SRL:  w_alu = w_b >> ShamtD;
            c_ALU_SRA:  w_alu = $signed(w_b) >>> ShamtD;
            c_ALU_LUI:  w_alu = {w_b[15:0], 16'h0000};
            default:    w_alu = 32'd0;
        endcase
    end

    // mfhi/mflo replace the ALU result with the HI/LO register
    always_comb begin
        case (MDOpD)
            c_MD_MFHI: w_result = w_hi;
            c_MD_MFLO: w_result = w_lo;
            default:   w_result = w_alu;
        endcase
    end

    execute_stage_md_unit #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_unit (
        .clk     (clk),
        .i_rst_n (reset),
        .i_md_op (MDOpD),
        .i_a     (w_a),
        .i_b     (w_bfwd),
        .o_hi    (w_hi),
        .o_lo    (w_lo),
        .o_busy  (w_busy),
        .o_stall (w_stall)
    );

    assign MDBusy  = w_busy;
    assign MDStall = w_stall;

    // E/M boundary; a stall inserts a bubble but PC still advances
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            SDtoRegE   <= 2'd0;
            ALUOutE    <= 32'd0;
            WriteDataE <= 32'd0;
            WriteRegE  <= 5'd0;
            PCE        <= 32'd0;
        end else begin
            PCE <= PCD;
            if (w_stall) begin
                RegWriteE  <= 1'b0;
                MemWriteE  <= 1'b0;
                SDtoRegE   <= 2'd0;
                ALUOutE    <= 32'd0;
                WriteDataE <= 32'd0;
                WriteRegE  <= 5'd0;
            end else begin
                RegWriteE  <= RegWriteD;
                MemWriteE  <= MemWriteD;
                SDtoRegE   <= SDtoRegD;
                ALUOutE    <= w_result;
                WriteDataE <= w_bfwd;
                WriteRegE  <= WriteRegD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Self-checking bench for execute_stage. A behavioural model
//                (integer arithmetic, remaining-cycle count for the MD unit)
//                predicts every E/M output and the stall request.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteD, MemWriteD, ALUSrcD;
    logic [1:0]  SDtoRegD, FwdAE, FwdBE;
    logic [3:0]  ALUCtrlD, MDOpD;
    logic [31:0] RD1D, RD2D, ImmD, PCD, FwdM, ResultW;
    logic [4:0]  ShamtD, WriteRegD;
    logic        RegWriteE, MemWriteE, MDBusy, MDStall;
    logic [1:0]  SDtoRegE;
    logic [31:0] ALUOutE, WriteDataE, PCE;
    logic [4:0]  WriteRegE;

    always #5 clk = ~clk;

    execute_stage #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .RegWriteD(RegWriteD), .SDtoRegD(SDtoRegD),
        .MemWriteD(MemWriteD), .ALUCtrlD(ALUCtrlD), .ALUSrcD(ALUSrcD), .MDOpD(MDOpD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .ShamtD(ShamtD), .WriteRegD(WriteRegD),
        .PCD(PCD), .FwdAE(FwdAE), .FwdBE(FwdBE), .FwdM(FwdM), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .SDtoRegE(SDtoRegE),
        .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .PCE(PCE),
        .MDBusy(MDBusy), .MDStall(MDStall)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    bit          m_pend_we;
    int          m_busy_left;

    // Expected values for the most recent step
    logic        e_stall, e_regwrite, e_memwrite, e_busy, obs_stall;
    logic [1:0]  e_sdtoreg;
    logic [31:0] e_aluout, e_wdata, e_pc;
    logic [4:0]  e_wreg;

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd,
                                        input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return rd;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_hi = 32'd0; m_lo = 32'd0; m_pend_hi = 32'd0; m_pend_lo = 32'd0;
        m_pend_we = 1'b0; m_busy_left = 0;
    endtask

    task automatic set_idle();
        RegWriteD = 1'b0; MemWriteD = 1'b0; ALUSrcD = 1'b0; SDtoRegD = 2'd0;
        FwdAE = 2'd0; FwdBE = 2'd0; ALUCtrlD = 4'd0; MDOpD = 4'd0;
        RD1D = 32'd0; RD2D = 32'd0; ImmD = 32'd0; ShamtD = 5'd0; WriteRegD = 5'd0;
        FwdM = 32'd0; ResultW = 32'd0;
    endtask

    // Runs one clock with the current inputs and advances the model.
    // Called just after a posedge; returns #1 after the next posedge.
    task automatic step();
        logic [31:0] a, bf, b;
        logic [63:0] p;
        a  = fwd(FwdAE, RD1D, FwdM, ResultW);
        bf = fwd(FwdBE, RD2D, FwdM, ResultW);
        b  = ALUSrcD ? ImmD : bf;
        e_stall = (MDOpD != 4'd0) && (m_busy_left > 0);
        #1 obs_stall = MDStall;
        e_pc = PCD;
        if (e_stall) begin
            e_regwrite = 1'b0; e_memwrite = 1'b0; e_sdtoreg = 2'd0;
            e_aluout = 32'd0; e_wdata = 32'd0; e_wreg = 5'd0;
        end else begin
            e_regwrite = RegWriteD; e_memwrite = MemWriteD; e_sdtoreg = SDtoRegD;
            e_wdata = bf; e_wreg = WriteRegD;
            if (MDOpD == 4'd5)      e_aluout = m_hi;
            else if (MDOpD == 4'd6) e_aluout = m_lo;
            else                    e_aluout = ref_alu(ALUCtrlD, a, b, ShamtD);
        end
        @(posedge clk);
        #1;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0 && m_pend_we) begin
                m_hi = m_pend_hi; m_lo = m_pend_lo;
            end
        end else if (!e_stall) begin
            case (MDOpD)
                4'd1: begin
                    p = 64'(longint'(int'(a)) * longint'(int'(bf)));
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                    m_pend_we = 1'b1; m_busy_left = MULT_CYCLES;
                end
                4'd2: begin
                    p = 64'(a) * 64'(bf);
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                    m_pend_we = 1'b1; m_busy_left = MULT_CYCLES;
                end
                4'd3: begin
                    m_pend_we = (bf != 32'd0); m_busy_left = DIV_CYCLES;
                    if (bf != 32'd0) begin
                        m_pend_lo = 32'(int'(a) / int'(bf));
                        m_pend_hi = 32'(int'(a) % int'(bf));
                    end
                end
                4'd4: begin
                    m_pend_we = (bf != 32'd0); m_busy_left = DIV_CYCLES;
                    if (bf != 32'd0) begin
                        m_pend_lo = a / bf;
                        m_pend_hi = a % bf;
                    end
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
                default: ;
            endcase
        end
        e_busy = (m_busy_left > 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        RD1D = 32'h1234_5678; RD2D = 32'h0000_0001; RegWriteD = 1'b1; PCD = 32'h0000_0040;
        MemWriteD = 1'b1; WriteRegD = 5'd3; MDOpD = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ALUOutE !== 32'd0) begin n_errors++; $display("FAIL reset_aluout got %h exp 0", ALUOutE); end
        n_checks++; if (PCE !== 32'd0) begin n_errors++; $display("FAIL reset_pce got %h exp 0", PCE); end
        n_checks++; if ({RegWriteE, MemWriteE, SDtoRegE} !== 4'd0) begin n_errors++; $display("FAIL reset_ctrl got %b exp 0", {RegWriteE, MemWriteE, SDtoRegE}); end
        n_checks++; if (WriteDataE !== 32'd0 || WriteRegE !== 5'd0) begin n_errors++; $display("FAIL reset_data got %h/%h exp 0", WriteDataE, WriteRegE); end
        n_checks++; if (MDBusy !== 1'b0 || MDStall !== 1'b0) begin n_errors++; $display("FAIL reset_md got %b%b exp 00", MDBusy, MDStall); end
        set_idle();
        PCD = 32'd0;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_alu_directed();
        set_idle(); ALUCtrlD = 4'd0; RD1D = 32'hFFFF_FFFF; RD2D = 32'd1; step();
        n_checks++; if (ALUOutE !== 32'd0) begin n_errors++; $display("FAIL add_wrap got %h exp 0", ALUOutE); end
        ALUCtrlD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'd1) begin n_errors++; $display("FAIL slt got %h exp 1", ALUOutE); end
        ALUCtrlD = 4'd7; step();
        n_checks++; if (ALUOutE !== 32'd0) begin n_errors++; $display("FAIL sltu got %h exp 0", ALUOutE); end
        ALUCtrlD = 4'd10; RD2D = 32'h8000_0000; ShamtD = 5'd4; step();
        n_checks++; if (ALUOutE !== 32'hF800_0000) begin n_errors++; $display("FAIL sra got %h exp f8000000", ALUOutE); end
        ALUCtrlD = 4'd11; ALUSrcD = 1'b1; ImmD = 32'h0000_ABCD; step();
        n_checks++; if (ALUOutE !== 32'hABCD_0000) begin n_errors++; $display("FAIL lui got %h exp abcd0000", ALUOutE); end
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            set_idle();
            ALUCtrlD = 4'($urandom_range(0, 11));
            RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; FwdM = $urandom; ResultW = $urandom;
            FwdAE = 2'($urandom_range(0, 3)); FwdBE = 2'($urandom_range(0, 3));
            ALUSrcD = 1'($urandom_range(0, 1)); ShamtD = 5'($urandom);
            RegWriteD = 1'($urandom); MemWriteD = 1'($urandom); SDtoRegD = 2'($urandom);
            WriteRegD = 5'($urandom); PCD = $urandom;
            step();
            n_checks++; if (ALUOutE !== e_aluout) begin n_errors++; $display("FAIL alu_rand op=%0d got %h exp %h", ALUCtrlD, ALUOutE, e_aluout); end
            n_checks++; if (WriteDataE !== e_wdata) begin n_errors++; $display("FAIL wdata_rand got %h exp %h", WriteDataE, e_wdata); end
            n_checks++; if ({RegWriteE, MemWriteE, SDtoRegE, WriteRegE, PCE} !== {e_regwrite, e_memwrite, e_sdtoreg, e_wreg, e_pc})
                begin n_errors++; $display("FAIL ctrl_rand got %b_%b_%b_%h_%h exp %b_%b_%b_%h_%h", RegWriteE, MemWriteE, SDtoRegE, WriteRegE, PCE, e_regwrite, e_memwrite, e_sdtoreg, e_wreg, e_pc); end
        end
    endtask

    task automatic test_forward();
        set_idle();
        RD1D = 32'd100; RD2D = 32'd5; FwdM = 32'd9; FwdBE = 2'd1; MemWriteD = 1'b1;
        ALUSrcD = 1'b1; ImmD = 32'd16; PCD = 32'h0000_0100;
        step();
        n_checks++; if (WriteDataE !== 32'd9) begin n_errors++; $display("FAIL fwd_wdata got %h exp 9", WriteDataE); end
        n_checks++; if (MemWriteE !== 1'b1) begin n_errors++; $display("FAIL fwd_memwrite got %b exp 1", MemWriteE); end
        n_checks++; if (ALUOutE !== 32'd116) begin n_errors++; $display("FAIL fwd_alu got %h exp 74", ALUOutE); end
        ALUSrcD = 1'b0; FwdAE = 2'd2; ResultW = 32'd1000; FwdBE = 2'd3; step();
        n_checks++; if (ALUOutE !== 32'd1005) begin n_errors++; $display("FAIL fwd_w_sel3 got %h exp 3ed", ALUOutE); end
    endtask

    task automatic test_mult();
        int stalls;
        set_idle();
        RD1D = 32'hFFFF_FFFD; RD2D = 32'd7; MDOpD = 4'd1; step();
        n_checks++; if (obs_stall !== 1'b0 || MDBusy !== 1'b1) begin n_errors++; $display("FAIL mult_issue got stall=%b busy=%b exp 0/1", obs_stall, MDBusy); end
        MDOpD = 4'd6; RegWriteD = 1'b1; WriteRegD = 5'd9; RD1D = 32'd1; RD2D = 32'd2; PCD = 32'h0000_0400;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!obs_stall) break;
            stalls++;
            n_checks++; if (RegWriteE !== 1'b0 || ALUOutE !== 32'd0 || WriteRegE !== 5'd0 || PCE !== 32'h0000_0400)
                begin n_errors++; $display("FAIL mult_bubble got rw=%b alu=%h wr=%h pc=%h exp 0/0/0/400", RegWriteE, ALUOutE, WriteRegE, PCE); end
        end
        n_checks++; if (stalls != MULT_CYCLES) begin n_errors++; $display("FAIL mult_stall_cycles got %0d exp %0d", stalls, MULT_CYCLES); end
        n_checks++; if (ALUOutE !== 32'hFFFF_FFEB) begin n_errors++; $display("FAIL mflo got %h exp ffffffeb", ALUOutE); end
        MDOpD = 4'd5; step();
        n_checks++; if (ALUOutE !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mfhi got %h exp ffffffff", ALUOutE); end
    endtask

    task automatic test_div();
        int busy_cnt;
        set_idle();
        RD1D = 32'd100; RD2D = 32'd7; MDOpD = 4'd4; step();
        MDOpD = 4'd0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (!MDBusy) break;
            busy_cnt++;
            step();
        end
        n_checks++; if (busy_cnt != DIV_CYCLES) begin n_errors++; $display("FAIL divu_busy_cycles got %0d exp %0d", busy_cnt, DIV_CYCLES); end
        MDOpD = 4'd5; step();
        n_checks++; if (ALUOutE !== 32'd2) begin n_errors++; $display("FAIL divu_hi got %h exp 2", ALUOutE); end
        MDOpD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'd14) begin n_errors++; $display("FAIL divu_lo got %h exp e", ALUOutE); end
        RD1D = 32'd55; RD2D = 32'd0; MDOpD = 4'd3; step();
        MDOpD = 4'd0;
        repeat (DIV_CYCLES + 1) step();
        MDOpD = 4'd5; step();
        n_checks++; if (ALUOutE !== 32'd2) begin n_errors++; $display("FAIL div0_hi got %h exp 2", ALUOutE); end
        MDOpD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'd14) begin n_errors++; $display("FAIL div0_lo got %h exp e", ALUOutE); end
        RD1D = 32'hCAFE_0001; MDOpD = 4'd7; step();
        RD1D = 32'hBEEF_0002; MDOpD = 4'd8; step();
        MDOpD = 4'd5; step();
        n_checks++; if (ALUOutE !== 32'hCAFE_0001) begin n_errors++; $display("FAIL mthi got %h exp cafe0001", ALUOutE); end
        MDOpD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'hBEEF_0002) begin n_errors++; $display("FAIL mtlo got %h exp beef0002", ALUOutE); end
    endtask

    task automatic test_reset_midop();
        set_idle();
        RD1D = 32'd1000; RD2D = 32'd3; MDOpD = 4'd3; PCD = 32'h0000_0800; RegWriteD = 1'b1; step();
        MDOpD = 4'd0; ALUCtrlD = 4'd0; step(); step();
        #2 reset = 1'b0;
        #1;
        n_checks++; if (ALUOutE !== 32'd0 || PCE !== 32'd0 || RegWriteE !== 1'b0) begin n_errors++; $display("FAIL midreset_out got alu=%h pc=%h rw=%b exp 0", ALUOutE, PCE, RegWriteE); end
        n_checks++; if (MDBusy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy got %b exp 0", MDBusy); end
        @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        set_idle();
        repeat (DIV_CYCLES + 2) step();
        n_checks++; if (MDBusy !== 1'b0) begin n_errors++; $display("FAIL midreset_idle got %b exp 0", MDBusy); end
        MDOpD = 4'd5; step();
        n_checks++; if (ALUOutE !== 32'd0) begin n_errors++; $display("FAIL midreset_hi got %h exp 0", ALUOutE); end
        MDOpD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'd0) begin n_errors++; $display("FAIL midreset_lo got %h exp 0", ALUOutE); end
    endtask

    task automatic test_overlap();
        set_idle();
        RD1D = 32'd6; RD2D = 32'd3; MDOpD = 4'd1; step();
        MDOpD = 4'd0; ALUCtrlD = 4'd0; RD1D = 32'h11; RD2D = 32'h22; RegWriteD = 1'b1; WriteRegD = 5'd7;
        step();
        n_checks++; if (obs_stall !== 1'b0) begin n_errors++; $display("FAIL overlap_stall got %b exp 0", obs_stall); end
        n_checks++; if (ALUOutE !== 32'h33 || RegWriteE !== 1'b1 || WriteRegE !== 5'd7) begin n_errors++; $display("FAIL overlap_add got %h/%b/%h exp 33/1/7", ALUOutE, RegWriteE, WriteRegE); end
        n_checks++; if (MDBusy !== 1'b1) begin n_errors++; $display("FAIL overlap_busy got %b exp 1", MDBusy); end
        MDOpD = 4'd0; repeat (MULT_CYCLES) step();
        MDOpD = 4'd6; step();
        n_checks++; if (ALUOutE !== 32'd18) begin n_errors++; $display("FAIL overlap_mflo got %h exp 12", ALUOutE); end
    endtask

    task automatic test_random_mixed();
        int r;
        for (int i = 0; i < 300; i++) begin
            set_idle();
            r = $urandom_range(0, 15);
            MDOpD = (r <= 8) ? 4'(r) : 4'd0;
            ALUCtrlD = 4'($urandom_range(0, 11));
            RD1D = $urandom; RD2D = $urandom; ImmD = $urandom; FwdM = $urandom; ResultW = $urandom;
            FwdAE = 2'($urandom_range(0, 3)); FwdBE = 2'($urandom_range(0, 3));
            ALUSrcD = 1'($urandom); ShamtD = 5'($urandom); RegWriteD = 1'($urandom);
            WriteRegD = 5'($urandom); PCD = $urandom;
            if (MDOpD == 4'd3 || MDOpD == 4'd4) begin
                FwdAE = 2'd0; RD1D[31] = 1'b0;
                if ($urandom_range(0, 7) == 0) begin FwdBE = 2'd0; RD2D = 32'd0; end
            end
            step();
            n_checks++; if (obs_stall !== e_stall) begin n_errors++; $display("FAIL mix_stall op=%0d got %b exp %b", MDOpD, obs_stall, e_stall); end
            n_checks++; if (ALUOutE !== e_aluout) begin n_errors++; $display("FAIL mix_aluout op=%0d md=%0d got %h exp %h", ALUCtrlD, MDOpD, ALUOutE, e_aluout); end
            n_checks++; if (MDBusy !== e_busy) begin n_errors++; $display("FAIL mix_busy got %b exp %b", MDBusy, e_busy); end
            n_checks++; if ({RegWriteE, WriteRegE, WriteDataE, PCE} !== {e_regwrite, e_wreg, e_wdata, e_pc})
                begin n_errors++; $display("FAIL mix_ctrl got %b_%h_%h_%h exp %b_%h_%h_%h", RegWriteE, WriteRegE, WriteDataE, PCE, e_regwrite, e_wreg, e_wdata, e_pc); end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_alu_directed();
        test_alu_random();
        test_forward();
        test_mult();
        test_div();
        test_reset_midop();
        test_overlap();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
